// File: rtl/riscv_dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
// The master drives requests; the slave returns one-cycle responses.
interface riscv_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_size,
    output req_unsigned,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_size,
    input  req_unsigned,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Latency-modelling 64-bit data memory for the MEM stage.
// DMEM_MISALIGN_TRAP_EN: misaligned accesses error instead of aligning down.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_dmem_responder_if.slave   bus,
  output logic [63:0]             mem0,
  output logic [63:0]             mem1,
  output logic [63:0]             mem2,
  output logic [63:0]             mem3
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS * 8);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ready_q;
  logic          rv_q;
  logic [63:0]   rdata_q;
  logic          err_q;

  logic          wr_q;
  logic [63:0]   addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [63:0]   wdata_q;

  logic [63:0]   mem [DEPTH_WORDS];

  logic [2:0]    lo_mask;
  logic [63:0]   bmask;
  logic [AW-1:0] idx;
  logic [2:0]    lane;
  logic [5:0]    sh;
  logic [63:0]   word;
  logic [63:0]   raw;
  logic [63:0]   load_c;
  logic [63:0]   wmask;
  logic [63:0]   wword;
  logic          oor;
  logic          err_c;

  always_comb begin
    lo_mask = 3'b000;
    bmask   = 64'hFF;
    unique case (size_q)
      2'd0: begin
        lo_mask = 3'b000;
        bmask   = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        lo_mask = 3'b001;
        bmask   = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        lo_mask = 3'b011;
        bmask   = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        lo_mask = 3'b111;
        bmask   = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  // Aligning down only touches the byte lane, never the word index
  assign idx  = addr_q[3 +: AW];
  assign lane = addr_q[2:0] & ~lo_mask;
  assign sh   = {lane, 3'b000};
  assign word = mem[idx];
  assign raw  = word >> sh;
  assign oor  = addr_q >= LIMIT;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |(addr_q[2:0] & lo_mask);
  assign err_c    = oor | misalign;
`else
  assign err_c    = oor;
`endif

  always_comb begin
    load_c = raw;
    unique case (size_q)
      2'd0: load_c = uns_q ? {56'b0, raw[7:0]}
                           : {{56{raw[7]}}, raw[7:0]};
      2'd1: load_c = uns_q ? {48'b0, raw[15:0]}
                           : {{48{raw[15]}}, raw[15:0]};
      2'd2: load_c = uns_q ? {32'b0, raw[31:0]}
                           : {{32{raw[31]}}, raw[31:0]};
      2'd3: load_c = raw;
    endcase
  end

  assign wmask = bmask << sh;
  assign wword = (word & ~wmask) | ((wdata_q << sh) & wmask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rv_q <= 1'b0;
          if (bus.req_valid && ready_q) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
            cnt     <= CW'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rv_q    <= 1'b1;
            err_q   <= err_c;
            rdata_q <= (err_c || wr_q) ? '0 : load_c;
            if (wr_q && !err_c)
              mem[idx] <= wword;
            state   <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          rv_q    <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign mem0 = mem[0];
  assign mem1 = mem[1];
  assign mem2 = mem[2];
  assign mem3 = mem[3];

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench for riscv_dmem_responder: vector table, scoreboard,
// plus reset-in-BUSY and held-valid throughput sequences.
module tb_riscv_dmem_responder;

  localparam int LATENCY = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] mem0, mem1, mem2, mem3;

  riscv_dmem_responder_if bus();

  riscv_dmem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem0(mem0),
    .mem1(mem1),
    .mem2(mem2),
    .mem3(mem3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] m0, m1, m2, m3;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [63:0] m0, m1, m2, m3;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic wr, input logic [63:0] addr, input logic [1:0] size,
    input logic uns, input logic [63:0] wdata, input logic [63:0] rdata,
    input logic err, input logic [63:0] m0, input logic [63:0] m1,
    input logic [63:0] m2, input logic [63:0] m3);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.m0 = m0; v.m1 = m1; v.m2 = m2; v.m3 = m3;
    return v;
  endfunction

  task automatic issue(input vec_t v, input int n);
    int k;
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", n);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    if (!bus.req_ready) return;
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_addr     = v.addr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata    = v.wdata;
    e.rdata = v.rdata; e.err = v.err;
    e.m0 = v.m0; e.m1 = v.m1; e.m2 = v.m2; e.m3 = v.m3;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_write    = ~v.wr;
    bus.req_addr     = {$urandom, $urandom};
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = ~v.uns;
    bus.req_wdata    = {$urandom, $urandom};
    k = 0;
    while (!bus.resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(LATENCY));
    if (bus.resp_valid) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      chk({tag, "_err"}, 64'(bus.resp_err), 64'(e.err));
      chk({tag, "_mem0"}, mem0, e.m0);
      chk({tag, "_mem1"}, mem1, e.m1);
      chk({tag, "_mem2"}, mem2, e.m2);
      chk({tag, "_mem3"}, mem3, e.m3);
    end else begin
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m1v, m0a, m0b, m2v, f12r;
    logic [7:0]  pv, pr;
    int          seen;
    m1v  = 64'h1122_3344_5566_7788;
    m0a  = 64'h0000_0000_DEAD_BEEF;
    m0b  = TRAP ? m0a : 64'h0000_0000_DEAD_5566;
    m2v  = 64'h0000_0000_AB00_0000;
    f12r = TRAP ? 64'd0 : 64'hFFFF_FFFF_DEAD_BEEF;

    vt.push_back(mk(0, 64'h0, 3, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 64'h8, 3, 0, m1v, 64'h0, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'h8, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF88, 0,
                    0, m1v, 0, 0));
    vt.push_back(mk(0, 64'h8, 0, 1, 0, 64'h88, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'hE, 1, 0, 0, 64'h1122, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'hC, 2, 0, 0, 64'h1122_3344, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'h8, 2, 1, 0, 64'h5566_7788, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'h8, 1, 0, 0, 64'h7788, 0, 0, m1v, 0, 0));
    vt.push_back(mk(0, 64'hF, 0, 0, 0, 64'h11, 0, 0, m1v, 0, 0));
    vt.push_back(mk(1, 64'h13, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 0,
                    0, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h13, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0,
                    0, m1v, m2v, 0));
    vt.push_back(mk(1, 64'h0, 2, 0, 64'h1234_5678_DEAD_BEEF, 64'h0, 0,
                    m0a, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h2, 2, 0, 0, f12r, TRAP, m0a, m1v, m2v, 0));
    vt.push_back(mk(1, 64'h1, 1, 0, 64'h5566, 64'h0, TRAP,
                    m0b, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h0, 2, 1, 0, m0b, 0, m0b, m1v, m2v, 0));
    vt.push_back(mk(1, 64'h200, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1,
                    m0b, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h1F8, 3, 0, 0, 64'h0, 0, m0b, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h200, 0, 0, 0, 64'h0, 1, m0b, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h1FF, 0, 1, 0, 64'h0, 0, m0b, m1v, m2v, 0));
    vt.push_back(mk(0, 64'h8, 3, 1, 0, m1v, 0, m0b, m1v, m2v, 0));

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_size = '0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_mems", 64'(|{mem0, mem1, mem2, mem3}), 64'd0);

    foreach (vt[i]) issue(vt[i], i);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // reset while BUSY with a store pending to doubleword 0
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h0;
    bus.req_size  = 2'd3;
    bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstbusy_ready", 64'(bus.req_ready), 64'd1);
    chk("rstbusy_mem0", mem0, 64'd0);
    chk("rstbusy_mem1", mem1, 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    chk("rstbusy_no_resp", 64'(seen), 64'd0);
    chk("rstbusy_mem0_late", mem0, 64'd0);

    // req_valid held high: accepts only from IDLE
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 64'h8;
    bus.req_size  = 2'd3;
    pv = '0;
    pr = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      pv[i] = bus.resp_valid;
      pr[i] = bus.req_ready;
      if (i == 2 || i == 6)
        chk($sformatf("held_rdata%0d", i), bus.resp_rdata, 64'd0);
    end
    bus.req_valid = 1'b0;
    chk("held_valid_pattern", 64'(pv), 64'h44);
    chk("held_ready_pattern", 64'(pr), 64'h88);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the pipelined RISC-V core's MEM stage. Accepts one load or store request at a time over a valid/ready handshake, waits a configurable number of cycles to model memory access time, then performs the access and returns a single-cycle response. It holds 64-bit little-endian doubleword storage and exposes the first four doublewords as debug taps for the testbench.

## Interface
- DEPTH_WORDS, 64, number of 64-bit doublewords; power of two, at least 4
- LATENCY, 2, cycles from request acceptance to memory access; must be at least 1
- clk  input  1  clock; all activity on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  input  1  load zero-extends when 1; sign-extends when 0
- req_wdata  input  64  store data; the low bytes are used, per req_size
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  64  load result; 0 for stores and on errors
- resp_err  output  1  access error, qualified by resp_valid
- mem0, mem1, mem2, mem3  output  64 each  live contents of doublewords 0 to 3

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid && req_ready) captures all req_* fields into internal registers.
  - Counter is loaded with LATENCY-1 and the FSM moves to BUSY.
- BUSY:
  - req_ready = 0.
  - Captured fields are used; changes on the req_* inputs are ignored.
  - If counter == 0: perform the access and move to RESP. Otherwise decrement the counter.
- RESP:
  - resp_valid = 1 with registered resp_rdata and resp_err; req_ready = 0.
  - Next state is always IDLE. There is no back-pressure.
- Address decode:
  - Word index = addr[3 +: log2(DEPTH_WORDS)].
  - Byte lane = addr[2:0].
  - Out of range when addr ≥ DEPTH_WORDS*8. Result: resp_err = 1, resp_rdata = 0, no write.
- Load:
  - Extract 1, 2, 4 or 8 bytes starting at the byte lane.
  - Extend to 64 bits: sign-extend when req_unsigned = 0, zero-extend when 1. req_unsigned is ignored for size 3.
- Store:
  - Overwrite only the addressed bytes with the low bytes of req_wdata, little-endian. All other bytes are preserved.
  - resp_rdata = 0.
- Misalignment (addr mod access size ≠ 0) is handled according to the Configuration section.
- Errors never modify memory.

## Timing
- Reset values:
  - FSM = IDLE, so req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
  - All memory words = 0, so mem0 to mem3 = 0.
- Request accepted at edge N → memory access at edge N+LATENCY → resp_valid high during the cycle after that edge, for exactly one cycle.
- req_ready returns to 1 on the edge after the resp_valid cycle. Maximum throughput is one request per LATENCY+2 cycles.
- mem0 to mem3 reflect a store starting the same cycle resp_valid rises.
- Reset while in BUSY or RESP:
  - The pending request is dropped and no resp_valid is produced.
  - Memory is cleared.
  - FSM is in IDLE on the edge reset is sampled low... more precisely, req_ready = 1 in the first cycle after reset deasserts.
- req_valid held high through the RESP cycle is not accepted until IDLE.

## Configuration
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access returns resp_err = 1 and resp_rdata = 0, and the store is suppressed.
- Undefined: the low address bits are masked to align down to the access size (addr & ~(size_bytes-1)). The access then completes normally with resp_err = 0.
- Out-of-range checking is always active in both builds.

## Test plan
- Reset, then load size 3 from addr 0x0, accepted at edge N → resp_valid in the cycle after edge N+2, resp_rdata = 0, resp_err = 0.
- Store size 3 of 0x1122334455667788 to addr 0x8 → mem1 = 0x1122334455667788.
  - Then signed byte load from 0x8 → 0xFFFFFFFFFFFFFF88.
  - Then unsigned byte load from 0x8 → 0x88.
- With memory cleared, store size 0 of 0xAB to addr 0x13 → mem2 = 0x00000000AB000000; mem0, mem1 and mem3 unchanged.
- Word load from addr 0x2 after storing 0xDEADBEEF to 0x0:
  - Macro defined → resp_err = 1, resp_rdata = 0.
  - Macro undefined → resp_rdata = 0xFFFFFFFFDEADBEEF, resp_err = 0.
- Store to addr 0x200 with DEPTH_WORDS = 64 → resp_err = 1; mem0 to mem3 and all other words unchanged.
- Reset asserted for one cycle while in BUSY during a store to 0x0 → no resp_valid, mem0 = 0, req_ready = 1 in the cycle after reset deasserts.
